uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Byte handshake between a producer and the buffered UART transmitter.
//   tx_data  : byte offered by the producer
//   tx_valid : producer has a byte on tx_data
//   tx_ready : transmitter FIFO can take a byte this cycle
// A byte is transferred on a rising clock edge where tx_valid && tx_ready.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8N1 UART transmitter. Bytes arrive over a valid/ready handshake into
// a circular FIFO and are serialised on tx at CLOCK_FREQ/BAUD_RATE clocks per
// bit: start bit (0), 8 data bits LSB first, stop bit (1). Queued bytes are sent
// back to back with no idle gap between frames.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset (truncates any frame in flight)
//   bus        : slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   tx         : registered serial output, idles high
//   busy       : FIFO non-empty or a frame is being shifted out
//   fifo_count : bytes waiting in the FIFO (the byte being shifted is excluded)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_fifo_if.slave               bus,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;
    localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Serializer state
    state_t        state_reg, state_next;
    logic [BW-1:0] baud_reg,  baud_next;
    logic [2:0]    bit_reg,   bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg,    tx_next;

    // FIFO state
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          ready;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // Ready depends only on the current count, so a pop on the same edge
    // never lets a push in early.
    assign ready        = (count_reg != COUNT_FULL);
    assign push         = bus.tx_valid && ready;
    assign head         = mem[rd_ptr_reg];

    assign bus.tx_ready = ready;
    assign tx           = tx_reg;
    assign busy         = (state_reg != IDLE) || (count_reg != '0);
    assign fifo_count   = count_reg;

    // ------------------------------------------------------------------
    // FIFO storage: no reset on the array; emptiness is tracked by the
    // pointers and count, so stale contents are never observed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.tx_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // ------------------------------------------------------------------
    // Serializer: next state. The baud counter restarts at 0 on every
    // state entry; a bit ends when it reaches BAUD_LAST.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg + BW'(1);
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;

        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    shift_next = head;
                    state_next = START;
                end
            end
            START: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        shift_next = head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase

        // tx is registered from the upcoming state so the line changes on
        // the same edge the state does.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo at 10 clocks per bit, 16-deep FIFO.
// Outputs are sampled on the falling clock edge; inputs change there too.
// A line monitor decodes every complete frame on tx into rx_q, which is
// compared against the bytes the bench accepted (exp_q).
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    uart_tx_fifo_if bus_if ();

    uart_tx_fifo #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if.slave),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cur_n = 0;
    bit saw_full = 0;

    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];
    logic [7:0] src   [$];

    typedef struct {
        int         n;     // sample point: cycles after the push edge
        logic       tx;
        logic       busy;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step_to(input int n);
        while (cur_n < n) begin
            @(negedge clk);
            cur_n++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int cyc = 0;
        while (busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic compare_rx(input string name);
        check({name, "_rx_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check({name, "_rx_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Offer every byte in src with tx_valid held high; move accepted ones to exp_q.
    task automatic send_all(input int limit);
        int cyc = 0;
        bit acc;
        bus_if.tx_valid = 1'b1;
        while (src.size() != 0 && cyc < limit) begin
            bus_if.tx_data = src[0];
            acc = bus_if.tx_ready;
            @(negedge clk);
            cyc++;
            if (acc) begin
                exp_q.push_back(src.pop_front());
            end
            if (fifo_count == 5'd16) begin
                check("ready_low_when_full", {31'd0, bus_if.tx_ready}, 32'd0);
                saw_full = 1'b1;
            end else begin
                check("ready_high_not_full", {31'd0, bus_if.tx_ready}, 32'd1);
            end
        end
        bus_if.tx_valid = 1'b0;
        check("send_timeout", src.size(), 32'd0);
    endtask

    // Line monitor: a frame begins at the first low sample; bit centres follow.
    initial begin : monitor
        logic [7:0] b;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ab = 1'b0;
                b  = '0;
                for (int i = 0; i < 9; i++) begin
                    for (int j = 0; j < ((i == 0) ? 15 : 10); j++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) ab = 1'b1;
                    end
                    if (i < 8) b[i] = tx;
                end
                // b[7] sampled at i=7; after the 9th wait we sit on the stop bit
                if (!ab) begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int low;
        bit dirty;

        // Single 0xA5 frame: push edge is sample 0; bits LSB first 1,0,1,0,0,1,0,1.
        tbl[0]  = '{0,   1'b1, 1'b1, 5'd1};
        tbl[1]  = '{1,   1'b0, 1'b1, 5'd0};
        tbl[2]  = '{10,  1'b0, 1'b1, 5'd0};
        tbl[3]  = '{11,  1'b1, 1'b1, 5'd0};
        tbl[4]  = '{20,  1'b1, 1'b1, 5'd0};
        tbl[5]  = '{21,  1'b0, 1'b1, 5'd0};
        tbl[6]  = '{31,  1'b1, 1'b1, 5'd0};
        tbl[7]  = '{41,  1'b0, 1'b1, 5'd0};
        tbl[8]  = '{51,  1'b0, 1'b1, 5'd0};
        tbl[9]  = '{61,  1'b1, 1'b1, 5'd0};
        tbl[10] = '{71,  1'b0, 1'b1, 5'd0};
        tbl[11] = '{80,  1'b0, 1'b1, 5'd0};
        tbl[12] = '{81,  1'b1, 1'b1, 5'd0};
        tbl[13] = '{90,  1'b1, 1'b1, 5'd0};
        tbl[14] = '{91,  1'b1, 1'b1, 5'd0};
        tbl[15] = '{100, 1'b1, 1'b1, 5'd0};
        tbl[16] = '{101, 1'b1, 1'b0, 5'd0};
        tbl[17] = '{110, 1'b1, 1'b0, 5'd0};

        rst_n           = 1'b0;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("reset_tx",       {31'd0, tx},              32'd1);
        check("reset_busy",     {31'd0, busy},            32'd0);
        check("reset_count",    {27'd0, fifo_count},      32'd0);
        check("reset_ready",    {31'd0, bus_if.tx_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_tx", {31'd0, tx}, 32'd1);

        // ---------------- single byte 0xA5, table driven ----------------
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'hA5;
        @(negedge clk);
        bus_if.tx_valid = 1'b0;
        cur_n = 0;
        for (int i = 0; i < 18; i++) begin
            step_to(tbl[i].n);
            check($sformatf("a5_tx_n%0d", tbl[i].n),    {31'd0, tx},         {31'd0, tbl[i].tx});
            check($sformatf("a5_busy_n%0d", tbl[i].n),  {31'd0, busy},       {31'd0, tbl[i].busy});
            check($sformatf("a5_count_n%0d", tbl[i].n), {27'd0, fifo_count}, {27'd0, tbl[i].cnt});
        end
        exp_q.push_back(8'hA5);
        compare_rx("a5");
        $display("a5 frame: checks so far total=%0d", total);

        // ---------------- 0x00 then 0xFF on consecutive edges ----------------
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h00;
        @(negedge clk);
        cur_n = 0;
        bus_if.tx_data = 8'hFF;
        step_to(1);
        bus_if.tx_valid = 1'b0;
        check("b2b_count_n1",  {27'd0, fifo_count}, 32'd1);
        check("b2b_tx_n1",     {31'd0, tx},         32'd0);
        step_to(90);
        check("b2b_tx_n90",    {31'd0, tx},         32'd0);
        step_to(91);
        check("b2b_stop_n91",  {31'd0, tx},         32'd1);
        step_to(100);
        check("b2b_stop_n100", {31'd0, tx},         32'd1);
        check("b2b_count_n100",{27'd0, fifo_count}, 32'd1);
        step_to(101);
        check("b2b_start_n101",{31'd0, tx},         32'd0);
        check("b2b_count_n101",{27'd0, fifo_count}, 32'd0);
        step_to(111);
        check("b2b_bit0_n111", {31'd0, tx},         32'd1);
        step_to(200);
        check("b2b_busy_n200", {31'd0, busy},       32'd1);
        step_to(201);
        check("b2b_busy_n201", {31'd0, busy},       32'd0);
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        compare_rx("b2b");
        $display("back-to-back 00/FF: checks so far total=%0d", total);

        // ---------------- 20 bytes with tx_valid held ----------------
        saw_full = 1'b0;
        for (int i = 0; i < 20; i++) src.push_back(8'(8'h10 + i));
        send_all(3000);
        check("twenty_saw_full", {31'd0, saw_full}, 32'd1);
        wait_idle(3000);
        compare_rx("twenty");
        $display("20-byte burst: checks so far total=%0d", total);

        // ---------------- constant 0x3C held while not ready ----------------
        for (int i = 0; i < 17; i++) src.push_back(8'(8'h40 + i));
        send_all(100);
        check("c3_full_count", {27'd0, fifo_count}, 32'd16);
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h3C;
        low = 0;
        while (!bus_if.tx_ready && low < 500) begin
            @(negedge clk);
            low++;
        end
        check("c3_ready_low_50", {31'd0, (low >= 50 && low < 500)}, 32'd1);
        @(negedge clk);
        bus_if.tx_valid = 1'b0;
        exp_q.push_back(8'h3C);
        check("c3_count_after_accept", {27'd0, fifo_count}, 32'd16);
        wait_idle(3000);
        compare_rx("c3");
        $display("0x3C hold: checks so far total=%0d", total);

        // ---------------- reset mid-frame ----------------
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h55;
        @(negedge clk);
        cur_n = 0;
        bus_if.tx_data = 8'h11;
        step_to(1);
        bus_if.tx_data = 8'h22;
        step_to(2);
        bus_if.tx_data = 8'h33;
        step_to(3);
        bus_if.tx_valid = 1'b0;
        check("rst_count_before", {27'd0, fifo_count}, 32'd3);
        step_to(35);
        check("rst_busy_before",  {31'd0, busy},       32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_tx",    {31'd0, tx},              32'd1);
        check("rst_count", {27'd0, fifo_count},      32'd0);
        check("rst_busy",  {31'd0, busy},            32'd0);
        check("rst_ready", {31'd0, bus_if.tx_ready}, 32'd1);
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        bus_if.tx_valid = 1'b0;
        rst_n = 1'b1;
        dirty = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_count != 5'd0 || busy !== 1'b0) dirty = 1'b1;
        end
        check("rst_line_idle_after", {31'd0, dirty}, 32'd0);
        check("rst_no_partial_frame", rx_q.size(), 32'd0);
        rx_q.delete();
        src.push_back(8'h81);
        send_all(10);
        wait_idle(300);
        compare_rx("rst_81");
        $display("reset mid-frame: checks so far total=%0d", total);

        // ---------------- push/pop same edge at count 5, 40 pushes ----------------
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'd3;
        exp_q.push_back(8'd3);
        @(negedge clk);
        cur_n = 0;
        for (int i = 1; i < 6; i++) begin
            bus_if.tx_data = 8'(i * 7 + 3);
            exp_q.push_back(8'(i * 7 + 3));
            step_to(i);
        end
        bus_if.tx_valid = 1'b0;
        check("pp_count_n5",   {27'd0, fifo_count}, 32'd5);
        step_to(100);
        check("pp_count_n100", {27'd0, fifo_count}, 32'd5);
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'(6 * 7 + 3);
        exp_q.push_back(8'(6 * 7 + 3));
        step_to(101);
        bus_if.tx_valid = 1'b0;
        check("pp_same_edge_count", {27'd0, fifo_count}, 32'd5);
        check("pp_same_edge_start", {31'd0, tx},         32'd0);
        for (int i = 7; i < 40; i++) src.push_back(8'(i * 7 + 3));
        send_all(5000);
        wait_idle(3000);
        compare_rx("wrap40");
        $display("push/pop and wrap: checks so far total=%0d", total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
